// File: rtl/ahb_lite_fifo_slave.sv
// ahb_lite_fifo_slave: AHB-Lite-style 8-bit slave with a FIFO behind DATA, programmable wait
// states, status/count registers and sticky overflow/underflow flags.
module ahb_lite_fifo_slave #(
    parameter int         DEPTH       = 4,
    parameter int         WAIT_STATES = 1,
    parameter logic [7:0] ADDR_DATA   = 8'h00,
    parameter logic [7:0] ADDR_STATUS = 8'h01,
    parameter logic [7:0] ADDR_COUNT  = 8'h02
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       write,
    input  logic       trans,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    output logic       readyout,
    output logic [7:0] rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [7:0]      addr_q, addr_d, rdata_q, rdata_d;
    logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic [7:0]      mem [DEPTH];
    logic            accept, full, empty, commit, push, pop, rd_w;
    logic [7:0]      rd_a, rsel;

    assign readyout = state_q != S_WAIT;
    assign rdata    = rdata_q;
    assign accept   = trans && readyout;
    assign full     = occ_q == CW'(DEPTH);
    assign empty    = occ_q == '0;
    assign commit   = state_q == S_DONE;
    assign push     = commit && wr_q && addr_q == ADDR_DATA && !full;
    assign pop      = commit && !wr_q && addr_q == ADDR_DATA && !empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        if (accept) begin
            state_d = WAIT_STATES > 0 ? S_WAIT : S_DONE;
            cnt_d   = 3'(WAIT_STATES - 1);
            wr_d    = write;
            addr_d  = waddr;
        end else if (state_q == S_WAIT) begin
            state_d = cnt_q == '0 ? S_DONE : S_WAIT;
            cnt_d   = cnt_q - 3'd1;
        end else begin
            state_d = S_IDLE;
        end
    end

    // Read data is selected from the access that is about to enter DONE
    always_comb begin
        rd_w    = accept ? write : wr_q;
        rd_a    = accept ? waddr : addr_q;
        rsel    = rd_a == ADDR_DATA   ? (empty ? 8'h00 : mem[rp_q]) :
                  rd_a == ADDR_STATUS ? {4'b0, unf_q, ovf_q, full, empty} :
                  rd_a == ADDR_COUNT  ? 8'(occ_q) : 8'h00;
        rdata_d = (state_d == S_DONE && !rd_w) ? rsel : 8'h00;
        wp_d    = wp_q + AW'(push);
        rp_d    = rp_q + AW'(pop);
        occ_d   = occ_q + CW'(push) - CW'(pop);
        ovf_d   = (ovf_q && !(commit && wr_q && addr_q == ADDR_STATUS && wdata[2])) ||
                  (commit && wr_q && addr_q == ADDR_DATA && full);
        unf_d   = (unf_q && !(commit && wr_q && addr_q == ADDR_STATUS && wdata[3])) ||
                  (commit && !wr_q && addr_q == ADDR_DATA && empty);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            occ_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            occ_q   <= occ_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wp_q] <= wdata;
    end
endmodule

// File: tb/tb_ahb_lite_fifo_slave.sv
// tb_ahb_lite_fifo_slave: directed table-driven checks plus back-to-back and async-reset sequences.
module tb_ahb_lite_fifo_slave;
    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       write = 1'b0;
    logic       trans = 1'b0;
    logic [7:0] waddr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       readyout;
    logic [7:0] rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] e;
    } vec_t;

    vec_t tbl[$];
    vec_t bb[$];

    ahb_lite_fifo_slave dut (
        .clock(clock), .rst_n(rst_n), .write(write), .trans(trans),
        .waddr(waddr), .wdata(wdata), .readyout(readyout), .rdata(rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.e = e;
        tbl.push_back(v);
    endtask

    // Single isolated transfer; returns rdata seen in the DONE cycle and number of wait cycles
    task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int ws);
        @(posedge clock); #1;
        trans = 1'b1; write = w; waddr = a; wdata = d;
        @(posedge clock); #1;
        trans = 1'b0;
        ws = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (readyout) break;
            ws++;
        end
        rd = rdata;
        @(posedge clock);
    endtask

    initial begin
        logic [7:0] rd;
        int ws;
        vec_t v;

        for (int i = 0; i < 5; i++) @(posedge clock);
        @(negedge clock);
        chk("reset_readyout", 8'(readyout), 8'h01);
        chk("reset_rdata", rdata, 8'h00);
        @(posedge clock); #1;
        rst_n = 1'b1;

        add(0, 8'h02, 8'h00, 8'h00);
        add(0, 8'h01, 8'h00, 8'h01);
        add(1, 8'h00, 8'hA5, 8'h00);
        add(0, 8'h02, 8'h00, 8'h01);
        add(0, 8'h00, 8'h00, 8'hA5);
        add(0, 8'h01, 8'h00, 8'h01);
        for (int i = 1; i <= 5; i++) add(1, 8'h00, 8'(i), 8'h00);
        add(0, 8'h01, 8'h00, 8'h06);
        add(0, 8'h02, 8'h00, 8'h04);
        for (int i = 1; i <= 4; i++) add(0, 8'h00, 8'h00, 8'(i));
        add(0, 8'h01, 8'h00, 8'h05);
        add(1, 8'h01, 8'h04, 8'h00);
        add(0, 8'h01, 8'h00, 8'h01);
        add(0, 8'h00, 8'h00, 8'h00);
        add(0, 8'h01, 8'h00, 8'h09);
        add(1, 8'h01, 8'h08, 8'h00);
        add(0, 8'h01, 8'h00, 8'h01);
        add(1, 8'h02, 8'h33, 8'h00);
        add(0, 8'h02, 8'h00, 8'h00);
        add(1, 8'h7F, 8'h55, 8'h00);
        add(0, 8'h7F, 8'h00, 8'h00);
        add(1, 8'h01, 8'h03, 8'h00);
        add(0, 8'h01, 8'h00, 8'h01);

        for (int i = 0; i < tbl.size(); i++) begin
            xfer(tbl[i].w, tbl[i].a, tbl[i].d, rd, ws);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].e);
            chk($sformatf("vec%0d_waits", i), 8'(ws), 8'h01);
        end

        // Back-to-back burst with trans held high: 6 writes, 6 reads, wrapping the pointers
        for (int i = 0; i < 4; i++) begin v.w = 1; v.a = 0; v.d = 8'h10 + 8'(i); v.e = 0; bb.push_back(v); end
        for (int i = 0; i < 4; i++) begin v.w = 0; v.a = 0; v.d = 0; v.e = 8'h10 + 8'(i); bb.push_back(v); end
        for (int i = 4; i < 6; i++) begin v.w = 1; v.a = 0; v.d = 8'h10 + 8'(i); v.e = 0; bb.push_back(v); end
        for (int i = 4; i < 6; i++) begin v.w = 0; v.a = 0; v.d = 0; v.e = 8'h10 + 8'(i); bb.push_back(v); end
        @(posedge clock); #1;
        trans = 1'b1; write = bb[0].w; waddr = 8'h00; wdata = bb[0].d;
        @(posedge clock);
        for (int k = 0; k < bb.size(); k++) begin
            #1;
            trans = k < bb.size() - 1;
            write = k < bb.size() - 1 ? bb[k+1].w : 1'b0;
            wdata = bb[k].d;
            @(negedge clock);
            chk($sformatf("bb%0d_wait", k), 8'(readyout), 8'h00);
            @(negedge clock);
            chk($sformatf("bb%0d_done", k), 8'(readyout), 8'h01);
            chk($sformatf("bb%0d_rdata", k), rdata, bb[k].e);
            @(posedge clock);
        end
        #1 trans = 1'b0;
        xfer(0, 8'h02, 8'h00, rd, ws);
        chk("bb_count", rd, 8'h00);
        xfer(0, 8'h01, 8'h00, rd, ws);
        chk("bb_status", rd, 8'h01);

        // Asynchronous reset asserted during the wait state of a DATA write
        @(posedge clock); #1;
        trans = 1'b1; write = 1'b1; waddr = 8'h00; wdata = 8'h77;
        @(posedge clock); #1;
        trans = 1'b0;
        @(negedge clock);
        chk("rst_mid_wait", 8'(readyout), 8'h00);
        #1 rst_n = 1'b0;
        #1 chk("rst_async_ready", 8'(readyout), 8'h01);
        chk("rst_async_rdata", rdata, 8'h00);
        @(posedge clock); @(posedge clock); #1;
        rst_n = 1'b1;
        xfer(0, 8'h02, 8'h00, rd, ws);
        chk("rst_count", rd, 8'h00);
        xfer(0, 8'h00, 8'h00, rd, ws);
        chk("rst_data_empty", rd, 8'h00);
        xfer(0, 8'h01, 8'h00, rd, ws);
        chk("rst_status", rd, 8'h09);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
